cpu_controller: RTL and testbench

Fetch/decode/execute sequencer for the 16-bit accumulator machine. It is the initiator on the main-memory port: it drives address, write data and write enable, and consumes the registered read data. It owns PC, IR and ACC, and uses the external ALU combinationally for arithmetic and logic. It sits at the top of the computer, between the main memory and the ALU.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_instr_decoder.sv | 35 +++
 rtl/cpu_controller.sv | 120 ++++++++++++
 tb/tb_cpu_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator machine controller:
// instruction opcodes, ALU opcodes, sequencer states and decode classes.
package cpu_pkg;

   localparam logic [3:0] OP_HALT  = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_JUMP  = 4'h8;
   localparam logic [3:0] OP_JUMPZ = 4'h9;
   localparam logic [3:0] OP_SHL   = 4'hA;
   localparam logic [3:0] OP_SHR   = 4'hB;
   localparam logic [3:0] OP_CLEAR = 4'hC;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;
   localparam logic [3:0] ALU_SHL = 4'b0100;
   localparam logic [3:0] ALU_SHR = 4'b0101;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_FETCH_WAIT,
      ST_DECODE,
      ST_READ,
      ST_READ_WAIT,
      ST_WRITE,
      ST_HALTED
   } state_t;

   // CLS_MEM instructions leave DECODE for READ or WRITE; CLS_EXEC ones finish in DECODE.
   typedef enum logic [1:0] {
      CLS_EXEC,
      CLS_HALT,
      CLS_MEM
   } cls_t;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational opcode decoder: next-state class, ALU opcode, and whether
// the instruction reads memory, stores, or writes the ALU result into ACC.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] i_opcode,
   output cls_t       o_cls,
   output logic [3:0] o_alu_op,
   output logic       o_needs_read,
   output logic       o_is_store,
   output logic       o_uses_alu
);

   always_comb begin
      o_cls        = CLS_EXEC;
      o_alu_op     = ALU_ADD;
      o_needs_read = 1'b0;
      o_is_store   = 1'b0;
      o_uses_alu   = 1'b0;
      case (i_opcode)
         OP_HALT:  o_cls = CLS_HALT;
         OP_LOAD:  begin o_cls = CLS_MEM; o_needs_read = 1'b1; end
         OP_STORE: begin o_cls = CLS_MEM; o_is_store = 1'b1; end
         OP_ADD:   begin o_cls = CLS_MEM; o_needs_read = 1'b1; o_uses_alu = 1'b1; o_alu_op = ALU_ADD; end
         OP_SUB:   begin o_cls = CLS_MEM; o_needs_read = 1'b1; o_uses_alu = 1'b1; o_alu_op = ALU_SUB; end
         OP_AND:   begin o_cls = CLS_MEM; o_needs_read = 1'b1; o_uses_alu = 1'b1; o_alu_op = ALU_AND; end
         OP_OR:    begin o_cls = CLS_MEM; o_needs_read = 1'b1; o_uses_alu = 1'b1; o_alu_op = ALU_OR;  end
         OP_XOR:   begin o_cls = CLS_MEM; o_needs_read = 1'b1; o_uses_alu = 1'b1; o_alu_op = ALU_XOR; end
         OP_SHL:   begin o_uses_alu = 1'b1; o_alu_op = ALU_SHL; end
         OP_SHR:   begin o_uses_alu = 1'b1; o_alu_op = ALU_SHR; end
         default:  o_cls = CLS_EXEC;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the accumulator machine; owns PC, IR
// and ACC, drives the memory port and steers the external ALU.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int OPND_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              halted
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_acc;
   logic              r_mem_we;
   logic              r_halted;

   logic [3:0]        w_opcode;
   logic [ADDR_W-1:0] w_x;
   cls_t              w_cls;
   logic [3:0]        w_dec_alu_op;
   logic              w_needs_read;
   logic              w_is_store;
   logic              w_uses_alu;
   logic              w_alu_active;

   assign w_opcode = r_ir[DATA_W-1 -: 4];
   assign w_x      = {{(ADDR_W-OPND_W){1'b0}}, r_ir[OPND_W-1:0]};

   instr_decoder u_dec (
      .i_opcode     (w_opcode),
      .o_cls        (w_cls),
      .o_alu_op     (w_dec_alu_op),
      .o_needs_read (w_needs_read),
      .o_is_store   (w_is_store),
      .o_uses_alu   (w_uses_alu)
   );

   // Shifts use the ALU in DECODE; binary ops use it in READ_WAIT.
   assign w_alu_active = w_uses_alu &&
                         ((r_state == ST_READ_WAIT) ||
                          ((r_state == ST_DECODE) && (w_cls == CLS_EXEC)));

   assign mem_addr  = ((r_state == ST_READ) || (r_state == ST_WRITE)) ? w_x : r_pc;
   assign mem_wdata = r_acc;
   assign mem_we    = r_mem_we;
   assign alu_op    = w_alu_active ? w_dec_alu_op : ALU_ADD;
   assign alu_a     = r_acc;
   assign alu_b     = mem_rdata;
   assign pc        = r_pc;
   assign acc       = r_acc;
   assign halted    = r_halted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_FETCH;
         r_pc     <= '0;
         r_ir     <= '0;
         r_acc    <= '0;
         r_mem_we <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            ST_FETCH: begin
               if (run) r_state <= ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
               r_ir    <= mem_rdata;
               r_pc    <= r_pc + 1'b1;
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_state <= ST_FETCH;
               if (w_cls == CLS_HALT) begin
                  r_state  <= ST_HALTED;
                  r_halted <= 1'b1;
               end else if (w_needs_read) begin
                  r_state <= ST_READ;
               end else if (w_is_store) begin
                  r_state  <= ST_WRITE;
                  r_mem_we <= 1'b1;
               end else begin
                  // Overrides the increment from FETCH_WAIT.
                  if ((w_opcode == OP_JUMP) || ((w_opcode == OP_JUMPZ) && (r_acc == '0)))
                     r_pc <= w_x;
                  if (w_uses_alu)
                     r_acc <= alu_result;
                  else if (w_opcode == OP_CLEAR)
                     r_acc <= '0;
               end
            end
            ST_READ:      r_state <= ST_READ_WAIT;
            ST_READ_WAIT: begin
               r_acc   <= w_uses_alu ? alu_result : mem_rdata;
               r_state <= ST_FETCH;
            end
            ST_WRITE:     r_state <= ST_FETCH;
            ST_HALTED:    r_state <= ST_HALTED;
            default:      r_state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed program walk-through followed by random
// programs checked against an instruction-level reference model.
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic [3:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic [15:0] pc;
   logic [15:0] acc;
   logic        halted;

   logic [15:0] mem  [0:65535];
   logic [15:0] rmem [0:65535];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cpu_controller #(.ADDR_W(16), .DATA_W(16), .OPND_W(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .pc         (pc),
      .acc        (acc),
      .halted     (halted)
   );

   // External ALU
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0001: alu_result = alu_a - alu_b;
         4'b1000: alu_result = alu_a & alu_b;
         4'b1001: alu_result = alu_a | alu_b;
         4'b1010: alu_result = alu_a ^ alu_b;
         4'b0100: alu_result = alu_a << 1;
         4'b0101: alu_result = alu_a >> 1;
         default: alu_result = 16'h0000;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: the memory samples the port mid-cycle and updates just after the edge.
   task automatic tick();
      logic [15:0] a;
      logic [15:0] d;
      logic        w;
      @(negedge clk);
      a = mem_addr;
      w = mem_we;
      d = mem_wdata;
      @(posedge clk);
      #1;
      if (w) mem[a] = d;
      else   mem_rdata = mem[a];
   endtask

   task automatic step_n(input int n, output int wc, output logic [15:0] wa, output logic [15:0] wd);
      wc = 0; wa = 16'h0; wd = 16'h0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (mem_we === 1'b1) begin
            wc++;
            wa = mem_addr;
            wd = mem_wdata;
         end
      end
   endtask

   initial begin
      int          wc;
      logic [15:0] wa, wd;
      logic [15:0] rpc, racc, npc, nacc, instr, x;
      logic [3:0]  op, acode;
      int          cyc, ak, stall;
      logic        hlt, st, rd;

      reset = 1'b1; run = 1'b0; mem_rdata = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h00] = 16'h1010; mem[16'h10] = 16'h1234;
      mem[16'h01] = 16'h3011; mem[16'h11] = 16'h0001;
      mem[16'h02] = 16'h2020;
      mem[16'h03] = 16'h9040;
      mem[16'h04] = 16'hC000;
      mem[16'h05] = 16'h9040;
      mem[16'h40] = 16'h0000;
      #2;
      chk("rst_addr", mem_addr, 16'h0);  chk("rst_we", mem_we, 1'b0);
      chk("rst_wdata", mem_wdata, 16'h0); chk("rst_aluop", alu_op, 4'h0);
      chk("rst_pc", pc, 16'h0); chk("rst_acc", acc, 16'h0); chk("rst_halted", halted, 1'b0);
      tick(); tick();
      reset = 1'b0; run = 1'b1;

      step_n(5, wc, wa, wd);
      chk("load_acc", acc, 16'h1234); chk("load_pc", pc, 16'h0001); chk("load_we", wc, 0);

      step_n(4, wc, wa, wd);
      chk("add_aluop", alu_op, 4'b0000);
      step_n(1, wc, wa, wd);
      chk("add_acc", acc, 16'h1235);

      step_n(4, wc, wa, wd);
      chk("store_wecnt", wc, 1); chk("store_addr", wa, 16'h0020);
      chk("store_wdata", wd, 16'h1235); chk("store_mem", mem[16'h20], 16'h1235);

      step_n(3, wc, wa, wd);
      chk("jumpz_nt_pc", pc, 16'h0004);
      step_n(3, wc, wa, wd);
      chk("clear_acc", acc, 16'h0); chk("clear_pc", pc, 16'h0005);
      step_n(3, wc, wa, wd);
      chk("jumpz_t_pc", pc, 16'h0040); chk("jumpz_t_acc", acc, 16'h0);

      run = 1'b0;
      step_n(10, wc, wa, wd);
      chk("stall_pc", pc, 16'h0040); chk("stall_addr", mem_addr, 16'h0040); chk("stall_we", wc, 0);
      run = 1'b1;
      step_n(3, wc, wa, wd);
      chk("halt_flag", halted, 1'b1); chk("halt_pc", pc, 16'h0041);
      for (int k = 0; k < 8; k++) begin
         run = ~run;
         tick();
      end
      chk("halt_hold_flag", halted, 1'b1); chk("halt_hold_pc", pc, 16'h0041);
      chk("halt_hold_we", mem_we, 1'b0);

      // Reset in the WRITE cycle must cancel the store.
      reset = 1'b1; run = 1'b0;
      mem[16'h00] = 16'h1031; mem[16'h01] = 16'h2030;
      mem[16'h31] = 16'h5A5A; mem[16'h30] = 16'hBEEF;
      tick();
      reset = 1'b0; run = 1'b1;
      step_n(5, wc, wa, wd);
      chk("rw_load_acc", acc, 16'h5A5A);
      step_n(3, wc, wa, wd);
      chk("rw_in_write", mem_we, 1'b1);
      reset = 1'b1;
      #1;
      chk("rw_we_drop", mem_we, 1'b0); chk("rw_pc", pc, 16'h0);
      chk("rw_acc", acc, 16'h0); chk("rw_addr", mem_addr, 16'h0); chk("rw_halted", halted, 1'b0);
      tick();
      chk("rw_mem_kept", mem[16'h30], 16'hBEEF);
      reset = 1'b0;
      step_n(5, wc, wa, wd);
      chk("rw_refetch_acc", acc, 16'h5A5A); chk("rw_refetch_pc", pc, 16'h0001);

      // Random programs against the instruction-level model.
      reset = 1'b1; run = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         mem[i]  = 16'($urandom);
         rmem[i] = mem[i];
      end
      tick();
      reset = 1'b0;
      rpc = 16'h0; racc = 16'h0;
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
         run = 1'b0;
         for (int s = 0; s < stall; s++) begin
            tick();
            chk("r_stall_pc", pc, rpc); chk("r_stall_we", mem_we, 1'b0);
         end
         run = 1'b1;
         instr = rmem[rpc];
         op = instr[15:12];
         x = {4'h0, instr[11:0]};
         npc = rpc + 16'h1; nacc = racc; hlt = 1'b0; st = 1'b0; rd = 1'b0;
         cyc = 3; ak = 0; acode = 4'h0;
         case (op)
            4'h0: hlt = 1'b1;
            4'h1: begin cyc = 5; rd = 1'b1; nacc = rmem[x]; end
            4'h2: begin cyc = 4; st = 1'b1; end
            4'h3: begin cyc = 5; rd = 1'b1; ak = 4; acode = 4'b0000; nacc = racc + rmem[x]; end
            4'h4: begin cyc = 5; rd = 1'b1; ak = 4; acode = 4'b0001; nacc = racc - rmem[x]; end
            4'h5: begin cyc = 5; rd = 1'b1; ak = 4; acode = 4'b1000; nacc = racc & rmem[x]; end
            4'h6: begin cyc = 5; rd = 1'b1; ak = 4; acode = 4'b1001; nacc = racc | rmem[x]; end
            4'h7: begin cyc = 5; rd = 1'b1; ak = 4; acode = 4'b1010; nacc = racc ^ rmem[x]; end
            4'h8: npc = x;
            4'h9: if (racc == 16'h0) npc = x;
            4'hA: begin ak = 2; acode = 4'b0100; nacc = {racc[14:0], 1'b0}; end
            4'hB: begin ak = 2; acode = 4'b0101; nacc = {1'b0, racc[15:1]}; end
            4'hC: nacc = 16'h0;
            default: ;
         endcase
         for (int k = 1; k <= cyc; k++) begin
            tick();
            if (k < cyc) begin
               run = 1'($urandom_range(0, 1));
               chk("r_we", mem_we, st && (k == 3));
               chk("r_aluop", alu_op, (k == ak) ? acode : 4'h0);
               if (k == 3 && (rd || st)) chk("r_opaddr", mem_addr, x);
               if (k == 3 && st) chk("r_wdata", mem_wdata, racc);
            end
         end
         if (st) begin
            rmem[x] = racc;
            chk("r_store_mem", mem[x], rmem[x]);
         end
         chk("r_pc", pc, npc); chk("r_acc", acc, nacc); chk("r_halted", halted, hlt);
         if (hlt) begin
            run = 1'b1;
            tick();
            chk("r_halt_hold_pc", pc, npc);
            reset = 1'b1;
            #1;
            chk("r_rst_pc", pc, 16'h0); chk("r_rst_halted", halted, 1'b0);
            tick();
            reset = 1'b0;
            rpc = 16'h0; racc = 16'h0;
         end else begin
            rpc = npc; racc = nacc;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
